egg_timer_counter: RTL and testbench
====================================

# egg_timer_counter

Time-keeping datapath for the egg timer, directly downstream of the timer controller FSM. Consumes the controller's 3-bit state and a user increment key, holds the MM:SS value as four BCD digits, decrements it once per second while running, and returns `cntfin` to the controller when the count reaches 00:00. Digit outputs feed the seven-segment display drivers.

## Interface
- `TICK_DIV`, 50000000: clk cycles per one-second tick; legal range ≥ 2.
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-high
- `state`  in  3  controller state: 000 setSec, 001 setMin, 010 stop, 011 start, 100 finish, 101 reset
- `inc`  in  1  increment key, level, synchronous to clk
- `sec_ones`  out  4  BCD seconds units, 0..9
- `sec_tens`  out  4  BCD seconds tens, 0..5
- `min_ones`  out  4  BCD minutes units, 0..9
- `min_tens`  out  4  BCD minutes tens, 0..9
- `cntfin`  out  1  count reached 00:00 (registered)
- `blink`  out  1  display blink enable during finish

## Operation
- Internal registers: the four digits, prescaler `pre` (width clog2(TICK_DIV)), `inc_q` (previous `inc`), `cntfin`, `blink`.
- `tick` = (`pre` == TICK_DIV-1) while `pre` is counting; `inc_rise` = `inc` & ~`inc_q`. `inc_q` updates every cycle.
- Per state:
  - reset (101): all digits ← 0, `pre` ← 0, `blink` ← 0.
  - setSec (000): `pre` ← 0; on `inc_rise`, seconds +1 in BCD, 59 → 00. No carry into minutes.
  - setMin (001): `pre` ← 0; on `inc_rise`, minutes +1 in BCD, 99 → 00.
  - stop (010): digits and `pre` hold (pause preserves sub-second phase).
  - start (011): `pre` increments, wraps TICK_DIV-1 → 0. On `tick` with value ≠ 00:00, decrement by one second: sec_ones 0 → 9 with borrow; sec_tens 0 → 5 with borrow; min_ones 0 → 9 with borrow; min_tens decrements. Value 00:00 is never decremented (no underflow).
  - finish (100): digits hold; `pre` counts as in start; on `tick`, `blink` toggles.
  - 110/111: treated as stop.
- `blink` ← 0 in every state other than finish.
- `cntfin` ← 1 when (state is start or finish) and next digit value is 00:00; otherwise ← 0.
- `inc` ignored in all states except setSec/setMin.

## Timing
- All outputs reset to 0 on `rst` at the rising clk edge; `rst` overrides every state action.
- Decrement occurs on the edge where `pre` == TICK_DIV-1 in start; next decrement TICK_DIV cycles later.
- Digit reaching 00:00 at edge N → `cntfin` high at edge N (same edge, computed from next value); controller sees it in cycle N+1.
- start entered with 00:00 → `cntfin` high at first start edge; digits stay 00:00.
- `inc` press: digit changes on the edge after `inc` first samples high; held `inc` gives one increment only.
- start → stop → start: `pre` resumes from held value; no tick lost or duplicated.
- State switching to setSec/setMin mid-second discards the partial second.
- `rst` mid-count: next cycle all digits 0, `pre` 0, `cntfin` 0.

## Configuration
- `EGG_TIMER_BLINK_EN`: defined → `blink` behaves as above. Undefined → `blink` tied to 0, toggle logic not synthesised; all other behaviour unchanged.

## Test plan
- TICK_DIV=4; rst 1 cycle → all digits 0, `cntfin` 0, `blink` 0.
- setSec, 61 `inc` pulses → seconds 01 (59 wraps to 00); setMin, 3 pulses → 03:01; held `inc` 10 cycles → exactly one increment.
- Load 01:00, start → after 4 cycles value 00:59; borrow chain verified; 00:10 → 00:09 → … → 00:00 with `cntfin` rising on the 00:00 edge and digits staying 00:00.
- Load 00:02, start 2 cycles, stop 10 cycles, start → first decrement exactly 2 cycles after resume.
- start with 00:00 → `cntfin` high next edge, no wrap to 99:59; state finish with define on → `blink` toggles every 4 cycles; define off → `blink` stays 0.
- Load 12:34, start, assert `rst` mid-second → next cycle 00:00, `cntfin` 0, `pre` 0.

Source files
------------

// File: rtl/egg_timer_counter.sv
// MM:SS BCD time-keeping datapath for the egg timer: set, count down once per tick, flag 00:00.
// Optional build macro EGG_TIMER_BLINK_EN enables the finish-state blink toggle.
module egg_timer_counter #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] state,
  input  logic       inc,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       cntfin,
  output logic       blink
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    ST_SET_SEC = 3'b000,
    ST_SET_MIN = 3'b001,
    ST_STOP    = 3'b010,
    ST_START   = 3'b011,
    ST_FINISH  = 3'b100,
    ST_RESET   = 3'b101
  } ctrl_state_t;

  ctrl_state_t    ctrl;
  logic [PW-1:0]  pre, pre_n;
  logic           inc_q;
  logic           inc_rise;
  logic           counting;
  logic           tick;
  logic           is_zero;
  logic           next_zero;
  logic [3:0]     so_n, st_n, mo_n, mt_n;
  logic           cntfin_n;

  assign ctrl     = ctrl_state_t'(state);
  assign inc_rise = inc & ~inc_q;
  assign counting = (ctrl == ST_START) || (ctrl == ST_FINISH);
  assign tick     = counting && (pre == PRE_MAX);
  assign is_zero  = (sec_ones == 4'd0) && (sec_tens == 4'd0) &&
                    (min_ones == 4'd0) && (min_tens == 4'd0);

  always_comb begin
    so_n  = sec_ones;
    st_n  = sec_tens;
    mo_n  = min_ones;
    mt_n  = min_tens;
    pre_n = pre;
    case (ctrl)
      ST_RESET: begin
        so_n  = 4'd0;
        st_n  = 4'd0;
        mo_n  = 4'd0;
        mt_n  = 4'd0;
        pre_n = '0;
      end
      ST_SET_SEC: begin
        pre_n = '0;
        if (inc_rise) begin
          if (sec_ones == 4'd9) begin
            so_n = 4'd0;
            st_n = (sec_tens == 4'd5) ? 4'd0 : sec_tens + 4'd1;
          end else begin
            so_n = sec_ones + 4'd1;
          end
        end
      end
      ST_SET_MIN: begin
        pre_n = '0;
        if (inc_rise) begin
          if (min_ones == 4'd9) begin
            mo_n = 4'd0;
            mt_n = (min_tens == 4'd9) ? 4'd0 : min_tens + 4'd1;
          end else begin
            mo_n = min_ones + 4'd1;
          end
        end
      end
      ST_START: begin
        pre_n = tick ? '0 : pre + PW'(1);
        // 00:00 is a floor: the borrow chain only runs on a non-zero value.
        if (tick && !is_zero) begin
          if (sec_ones != 4'd0) begin
            so_n = sec_ones - 4'd1;
          end else begin
            so_n = 4'd9;
            if (sec_tens != 4'd0) begin
              st_n = sec_tens - 4'd1;
            end else begin
              st_n = 4'd5;
              if (min_ones != 4'd0) begin
                mo_n = min_ones - 4'd1;
              end else begin
                mo_n = 4'd9;
                mt_n = min_tens - 4'd1;
              end
            end
          end
        end
      end
      ST_FINISH: begin
        pre_n = tick ? '0 : pre + PW'(1);
      end
      default: begin
        pre_n = pre;
      end
    endcase
  end

  assign next_zero = (so_n == 4'd0) && (st_n == 4'd0) && (mo_n == 4'd0) && (mt_n == 4'd0);
  assign cntfin_n  = counting && next_zero;

  // inc_q tracks the key every cycle so a key held through reset is not seen as a new press.
  always_ff @(posedge clk) begin
    inc_q <= inc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min_ones <= 4'd0;
      min_tens <= 4'd0;
      pre      <= '0;
      cntfin   <= 1'b0;
    end else begin
      sec_ones <= so_n;
      sec_tens <= st_n;
      min_ones <= mo_n;
      min_tens <= mt_n;
      pre      <= pre_n;
      cntfin   <= cntfin_n;
    end
  end

`ifdef EGG_TIMER_BLINK_EN
  logic blink_n;

  always_comb begin
    blink_n = 1'b0;
    if (ctrl == ST_FINISH) begin
      blink_n = tick ? ~blink : blink;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink <= 1'b0;
    end else begin
      blink <= blink_n;
    end
  end
`else
  assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_egg_timer_counter.sv
// Bench for egg_timer_counter: seconds-based reference model checked every cycle, plus literal anchors.
module tb_egg_timer_counter;
  localparam int TD = 4;

  logic       clk;
  logic       rst;
  logic [2:0] state;
  logic       inc;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       cntfin, blink;

  int vectors = 0;
  int miscompares = 0;

  logic [17:0] exp_q[$];

  // model state: whole minutes/seconds as integers, prescaler as a plain count
  int m_min = 0, m_sec = 0, m_pre = 0;
  bit m_cnt = 0, m_blink = 0, m_inc_q = 0;

  egg_timer_counter #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .state(state), .inc(inc),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
    .cntfin(cntfin), .blink(blink)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model, advanced on every rising edge
  always @(posedge clk) begin
    int  total;
    bit  tick, rise;
    rise = inc && !m_inc_q;
    m_inc_q = inc;
    if (rst) begin
      m_min = 0; m_sec = 0; m_pre = 0; m_cnt = 0; m_blink = 0;
    end else begin
      tick = 0;
      case (state)
        3'd5: begin m_min = 0; m_sec = 0; m_pre = 0; end
        3'd0: begin m_pre = 0; if (rise) m_sec = (m_sec + 1) % 60; end
        3'd1: begin m_pre = 0; if (rise) m_min = (m_min + 1) % 100; end
        3'd3, 3'd4: begin
          tick = (m_pre == TD - 1);
          m_pre = (m_pre + 1) % TD;
        end
        default: ;
      endcase
      if (state == 3'd3 && tick) begin
        total = m_min * 60 + m_sec;
        if (total > 0) total = total - 1;
        m_min = total / 60;
        m_sec = total % 60;
      end
`ifdef EGG_TIMER_BLINK_EN
      if (state == 3'd4) begin
        if (tick) m_blink = !m_blink;
      end else begin
        m_blink = 0;
      end
`else
      m_blink = 0;
`endif
      m_cnt = (state == 3'd3 || state == 3'd4) && (m_min == 0 && m_sec == 0);
    end
    exp_q.push_back({4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10), m_cnt, m_blink});
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    logic [17:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cycle", {14'd0, min_tens, min_ones, sec_tens, sec_ones, cntfin, blink}, {14'd0, e});
    end
  end

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int n);
    repeat (n) begin
      inc = 1'b1; @(negedge clk);
      inc = 1'b0; @(negedge clk);
    end
  endtask

  task automatic load(input int mins, input int secs);
    state = 3'd5; cycles(1);
    state = 3'd0; pulse(secs);
    state = 3'd1; pulse(mins);
  endtask

  function automatic logic [31:0] digits();
    return {16'd0, min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  initial begin
    rst = 1'b1; state = 3'd5; inc = 1'b0;
    cycles(2);
    check("reset_digits", digits(), 32'h0000);
    check("reset_cntfin", {31'd0, cntfin}, 32'd0);
    check("reset_blink", {31'd0, blink}, 32'd0);
    rst = 1'b0;

    state = 3'd0; pulse(61);
    check("set_sec_wrap", digits(), 32'h0001);
    state = 3'd1; pulse(3);
    check("set_min", digits(), 32'h0301);
    inc = 1'b1; cycles(10); inc = 1'b0; cycles(1);
    check("held_inc_once", digits(), 32'h0401);

    load(1, 0);
    check("load_0100", digits(), 32'h0100);
    state = 3'd3; cycles(3);
    check("pre_tick_hold", digits(), 32'h0100);
    cycles(1);
    check("borrow_chain", digits(), 32'h0059);

    load(0, 10);
    state = 3'd3; cycles(39);
    check("before_zero", digits(), 32'h0001);
    check("before_zero_cnt", {31'd0, cntfin}, 32'd0);
    cycles(1);
    check("at_zero", digits(), 32'h0000);
    check("at_zero_cnt", {31'd0, cntfin}, 32'd1);
    cycles(10);
    check("no_underflow", digits(), 32'h0000);

    load(0, 2);
    state = 3'd3; cycles(2);
    state = 3'd2; cycles(10);
    check("pause_hold", digits(), 32'h0002);
    state = 3'd3; cycles(1);
    check("resume_1", digits(), 32'h0002);
    cycles(1);
    check("resume_2", digits(), 32'h0001);

    load(0, 0);
    state = 3'd3; cycles(1);
    check("start_zero_cnt", {31'd0, cntfin}, 32'd1);
    cycles(8);
    check("start_zero_digits", digits(), 32'h0000);

    state = 3'd0; cycles(1);
    state = 3'd4; cycles(4);
`ifdef EGG_TIMER_BLINK_EN
    check("blink_on", {31'd0, blink}, 32'd1);
`else
    check("blink_on", {31'd0, blink}, 32'd0);
`endif
    cycles(4);
    check("blink_off", {31'd0, blink}, 32'd0);
    state = 3'd2; cycles(1);
    check("blink_clear", {31'd0, blink}, 32'd0);

    load(12, 34);
    state = 3'd3; cycles(2);
    rst = 1'b1; cycles(1);
    check("rst_mid_digits", digits(), 32'h0000);
    check("rst_mid_cnt", {31'd0, cntfin}, 32'd0);
    rst = 1'b0; cycles(4);

    // randomized traffic: start-heavy state mix, random key levels, rare resets
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 1) == 0) state = 3'd3;
      else state = 3'($urandom_range(0, 7));
      inc = 1'($urandom_range(0, 1));
      cycles(1);
    end
    rst = 1'b0; inc = 1'b0; state = 3'd2;
    cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
